calc_operand_sequencer: RTL and testbench

- Control/datapath stage that feeds `adder32` and consumes its result.
- On `start_i` it walks an operand memory region, reading operand A at address n and operand B at address n+1.
- Registered operands drive the adder; each sum is written to a result region.
- Runs to completion of the read range, then pulses `done_o`. Sits between the top-level calculator control and the operand/result SRAM.

---
 rtl/calculator_pkg.sv | 21 ++
 rtl/calc_operand_sequencer.sv | 160 ++++++++++++++++
 tb/tb_calc_operand_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calculator_pkg.sv
// Shared widths, FSM state encoding and word/address types for the calculator
// datapath blocks.
package calculator_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_A,
    S_READ_B,
    S_WAIT_B,
    S_ADD,
    S_WRITE,
    S_DONE
  } state_t;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/calc_operand_sequencer.sv
// Operand sequencer: walks an operand region two words at a time, presents each
// pair to an external adder through registered operands and writes every sum to
// a result region. Pulses done_o once the read range is exhausted.
// Optional build macro CALC_OVERFLOW_FLAG_EN adds a sticky signed-overflow
// output ovf_o.
module calc_operand_sequencer
  import calculator_pkg::*;
#(
  parameter int DATA_W = calculator_pkg::DATA_W,
  parameter int ADDR_W = calculator_pkg::ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] read_start_addr_i,
  input  logic [ADDR_W-1:0] read_end_addr_i,
  input  logic [ADDR_W-1:0] write_start_addr_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic [DATA_W-1:0] op_a_o,
  output logic [DATA_W-1:0] op_b_o,
  input  logic [DATA_W-1:0] sum_i,
  output logic              busy_o,
  output logic              done_o
`ifdef CALC_OVERFLOW_FLAG_EN
  ,
  output logic              ovf_o
`endif
);

  // Read pointer carries one extra bit so the end-of-range test can never be
  // fooled by a wrap back to low addresses.
  state_t              r_state;
  logic [ADDR_W:0]     r_rptr;
  logic [ADDR_W-1:0]   r_rend;
  logic [ADDR_W-1:0]   r_wptr;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic [DATA_W-1:0]   r_result;

  logic [ADDR_W:0]     w_first_b_addr;
  logic [ADDR_W:0]     w_rend_ext;
  logic [ADDR_W:0]     w_next_rptr;
  logic [ADDR_W:0]     w_next_b_addr;
  logic [ADDR_W-1:0]   w_b_rd_addr;

  assign w_first_b_addr = {1'b0, read_start_addr_i} + (ADDR_W+1)'(1);
  assign w_rend_ext     = {1'b0, r_rend};
  assign w_next_rptr    = r_rptr + (ADDR_W+1)'(2);
  assign w_next_b_addr  = r_rptr + (ADDR_W+1)'(3);
  assign w_b_rd_addr    = r_rptr[ADDR_W-1:0] + ADDR_W'(1);

  // FSM, pointers and operand/result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_rptr   <= '0;
      r_rend   <= '0;
      r_wptr   <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_rptr <= {1'b0, read_start_addr_i};
            r_rend <= read_end_addr_i;
            r_wptr <= write_start_addr_i;
            // A range shorter than two words holds no complete pair.
            if (w_first_b_addr > {1'b0, read_end_addr_i}) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_READ_A;
            end
          end
        end
        S_READ_A: r_state <= S_READ_B;
        S_READ_B: begin
          r_op_a  <= rd_data_i;
          r_state <= S_WAIT_B;
        end
        S_WAIT_B: begin
          r_op_b  <= rd_data_i;
          r_state <= S_ADD;
        end
        S_ADD: begin
          r_result <= sum_i;
          r_state  <= S_WRITE;
        end
        S_WRITE: begin
          r_wptr <= r_wptr + ADDR_W'(1);
          r_rptr <= w_next_rptr;
          // Continue only if the next pair's B word is still inside the range.
          if (w_next_b_addr <= w_rend_ext) begin
            r_state <= S_READ_A;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CALC_OVERFLOW_FLAG_EN
  logic r_ovf;

  // Sticky signed overflow: same operand signs, result sign differs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_IDLE && start_i) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_ADD &&
                 r_op_a[DATA_W-1] == r_op_b[DATA_W-1] &&
                 sum_i[DATA_W-1] != r_op_a[DATA_W-1]) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf_o = r_ovf;
`endif

  // Memory strobes and addresses decoded from state; idle buses are driven to 0.
  always_comb begin
    rd_en_o   = 1'b0;
    rd_addr_o = '0;
    wr_en_o   = 1'b0;
    wr_addr_o = '0;
    wr_data_o = '0;
    case (r_state)
      S_READ_A: begin
        rd_en_o   = 1'b1;
        rd_addr_o = r_rptr[ADDR_W-1:0];
      end
      S_READ_B: begin
        rd_en_o   = 1'b1;
        rd_addr_o = w_b_rd_addr;
      end
      S_WRITE: begin
        wr_en_o   = 1'b1;
        wr_addr_o = r_wptr;
        wr_data_o = r_result;
      end
      default: ;
    endcase
  end

  assign op_a_o = r_op_a;
  assign op_b_o = r_op_b;
  assign busy_o = (r_state != S_IDLE);
  assign done_o = (r_state == S_DONE);

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Directed bench for calc_operand_sequencer with a registered-read memory model
// and a behavioural adder. Build with CALC_OVERFLOW_FLAG_EN to cover ovf_o.
module tb_calc_operand_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [8:0]  read_start_addr_i;
  logic [8:0]  read_end_addr_i;
  logic [8:0]  write_start_addr_i;
  logic        rd_en_o;
  logic [8:0]  rd_addr_o;
  logic [31:0] rd_data_i;
  logic        wr_en_o;
  logic [8:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic [31:0] op_a_o;
  logic [31:0] op_b_o;
  logic [31:0] sum_i;
  logic        busy_o;
  logic        done_o;
`ifdef CALC_OVERFLOW_FLAG_EN
  logic        ovf_o;
`endif

  calc_operand_sequencer dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .start_i            (start_i),
    .read_start_addr_i  (read_start_addr_i),
    .read_end_addr_i    (read_end_addr_i),
    .write_start_addr_i (write_start_addr_i),
    .rd_en_o            (rd_en_o),
    .rd_addr_o          (rd_addr_o),
    .rd_data_i          (rd_data_i),
    .wr_en_o            (wr_en_o),
    .wr_addr_o          (wr_addr_o),
    .wr_data_o          (wr_data_o),
    .op_a_o             (op_a_o),
    .op_b_o             (op_b_o),
    .sum_i              (sum_i),
    .busy_o             (busy_o),
    .done_o             (done_o)
`ifdef CALC_OVERFLOW_FLAG_EN
    ,
    .ovf_o              (ovf_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Memory model: one-cycle registered read.
  logic [31:0] mem [512];
  always @(posedge clk_i) begin
    if (rd_en_o) rd_data_i <= mem[rd_addr_o];
  end

  // Behavioural stand-in for adder32.
  assign sum_i = op_a_o + op_b_o;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Per-run observation log.
  logic [8:0]  wa [$];
  logic [31:0] wd [$];
  int          done_cyc;
  int          busy_cnt;
  int          rd_cnt;
  bit          saw6;
  bit          stray;
  logic        ovf_at_done;

  task automatic clear_log();
    wa.delete();
    wd.delete();
    done_cyc    = -1;
    busy_cnt    = 0;
    rd_cnt      = 0;
    saw6        = 1'b0;
    stray       = 1'b0;
    ovf_at_done = 1'b0;
  endtask

  // Sample one cycle at the falling edge and log what the DUT did.
  task automatic sample(input int c);
    @(negedge clk_i);
    if (busy_o) busy_cnt++;
    if (rd_en_o) begin
      rd_cnt++;
      if (rd_addr_o == 9'd6) saw6 = 1'b1;
    end else if (rd_addr_o != '0) begin
      stray = 1'b1;
    end
    if (wr_en_o) begin
      wa.push_back(wr_addr_o);
      wd.push_back(wr_data_o);
    end else if (wr_addr_o != '0 || wr_data_o != '0) begin
      stray = 1'b1;
    end
    if (done_o && done_cyc < 0) begin
      done_cyc = c;
`ifdef CALC_OVERFLOW_FLAG_EN
      ovf_at_done = ovf_o;
`endif
    end
  endtask

  // Drive start so that the next rising edge is edge 0 of the run.
  task automatic launch(input logic [8:0] rs, input logic [8:0] re, input logic [8:0] ws,
                        input bit hold);
    @(negedge clk_i);
    read_start_addr_i  = rs;
    read_end_addr_i    = re;
    write_start_addr_i = ws;
    start_i            = 1'b1;
    @(posedge clk_i);
    #1;
    if (!hold) start_i = 1'b0;
    clear_log();
  endtask

  // Observe until done_o, bounded by a cycle budget.
  task automatic watch(input int budget);
    for (int c = 1; c <= budget; c++) begin
      sample(c);
      if (done_cyc >= 0) break;
    end
  endtask

  task automatic show_run(input string name);
    $display("run %s: writes=%0d done_cycle=%0d reads=%0d", name, wa.size(), done_cyc, rd_cnt);
  endtask

  initial begin
    start_i            = 1'b0;
    read_start_addr_i  = '0;
    read_end_addr_i    = '0;
    write_start_addr_i = '0;
    rd_data_i          = '0;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_rd_en", rd_en_o, 0);
    chk("rst_wr_en", wr_en_o, 0);
    chk("rst_op_a", op_a_o, 0);
    chk("rst_op_b", op_b_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Single pair 5+7.
    mem[0] = 32'd5; mem[1] = 32'd7;
    launch(9'd0, 9'd1, 9'd100, 1'b0);
    watch(20);
    show_run("single");
    chk("t1_done_cyc", done_cyc, 6);
    chk("t1_nwr", wa.size(), 1);
    if (wa.size() == 1) begin
      chk("t1_waddr", wa[0], 100);
      chk("t1_wdata", wd[0], 12);
    end
    chk("t1_busy_cycles", busy_cnt, 6);
    chk("t1_reads", rd_cnt, 2);
    chk("t1_stray", stray, 0);
    chk("t1_op_a", op_a_o, 5);
    chk("t1_op_b", op_b_o, 7);
    @(negedge clk_i);
    chk("t1_idle_after", busy_o, 0);
    chk("t1_done_once", done_o, 0);

    // Three pairs with wrap-around of the write pointer.
    mem[0] = 32'hFFFF_FFFF; mem[1] = 32'h1;
    mem[2] = 32'h8000_0000; mem[3] = 32'h8000_0000;
    mem[4] = 32'd3;         mem[5] = 32'd4;
    launch(9'd0, 9'd5, 9'h1FF, 1'b0);
    watch(40);
    show_run("wrap");
    chk("t2_done_cyc", done_cyc, 16);
    chk("t2_nwr", wa.size(), 3);
    if (wa.size() == 3) begin
      chk("t2_wa0", wa[0], 9'h1FF);
      chk("t2_wd0", wd[0], 0);
      chk("t2_wa1", wa[1], 9'h000);
      chk("t2_wd1", wd[1], 0);
      chk("t2_wa2", wa[2], 9'h001);
      chk("t2_wd2", wd[2], 7);
    end
    chk("t2_stray", stray, 0);

    // Odd-length range: trailing word at 6 is never read.
    launch(9'd4, 9'd6, 9'd50, 1'b0);
    watch(20);
    show_run("odd");
    chk("t3_done_cyc", done_cyc, 6);
    chk("t3_nwr", wa.size(), 1);
    if (wa.size() == 1) begin
      chk("t3_waddr", wa[0], 50);
      chk("t3_wdata", wd[0], 7);
    end
    chk("t3_no_addr6", saw6, 0);
    chk("t3_reads", rd_cnt, 2);

    // Empty range: start above end.
    launch(9'd7, 9'd6, 9'd60, 1'b0);
    watch(10);
    show_run("empty");
    chk("t4_done_cyc", done_cyc, 1);
    chk("t4_reads", rd_cnt, 0);
    chk("t4_nwr", wa.size(), 0);

    // start_i held high through a run: one run, then a back-to-back run.
    mem[30] = 32'd100; mem[31] = 32'd23;
    launch(9'd30, 9'd31, 9'd70, 1'b1);
    watch(20);
    show_run("held");
    chk("t5_done_cyc", done_cyc, 6);
    chk("t5_nwr", wa.size(), 1);
    if (wa.size() == 1) chk("t5_wdata", wd[0], 123);
    @(negedge clk_i);
    chk("t5_idle_gap_busy", busy_o, 0);
    chk("t5_idle_gap_done", done_o, 0);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    clear_log();
    watch(20);
    show_run("held_second");
    chk("t5b_done_cyc", done_cyc, 6);
    chk("t5b_nwr", wa.size(), 1);
    if (wa.size() == 1) chk("t5b_waddr", wa[0], 70);

    // Reset asserted during the WRITE of pair 2 of 3.
    mem[10] = 32'd10; mem[11] = 32'd20;
    mem[12] = 32'd30; mem[13] = 32'd40;
    mem[14] = 32'd50; mem[15] = 32'd60;
    launch(9'd10, 9'd15, 9'd200, 1'b0);
    for (int c = 1; c <= 10; c++) sample(c);
    chk("t6_pre_wr_en", wr_en_o, 1);
    chk("t6_pre_wr_addr", wr_addr_o, 201);
    chk("t6_pre_wr_data", wr_data_o, 70);
    rst_i = 1'b1;
    #1;
    chk("t6_rst_wr_en", wr_en_o, 0);
    chk("t6_rst_rd_en", rd_en_o, 0);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_wdata", wr_data_o, 0);
    chk("t6_rst_op_a", op_a_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    clear_log();
    for (int c = 1; c <= 8; c++) sample(c);
    chk("t6_quiet_reads", rd_cnt, 0);
    chk("t6_quiet_writes", wa.size(), 0);
    chk("t6_quiet_busy", busy_cnt, 0);
    launch(9'd10, 9'd15, 9'd200, 1'b0);
    watch(40);
    show_run("after_reset");
    chk("t6_done_cyc", done_cyc, 16);
    chk("t6_nwr", wa.size(), 3);
    if (wa.size() == 3) begin
      chk("t6_wd0", wd[0], 30);
      chk("t6_wa2", wa[2], 202);
      chk("t6_wd2", wd[2], 110);
    end

`ifdef CALC_OVERFLOW_FLAG_EN
    mem[20] = 32'h7FFF_FFFF; mem[21] = 32'h1;
    launch(9'd20, 9'd21, 9'd80, 1'b0);
    watch(20);
    show_run("ovf_set");
    chk("t7_ovf_at_done", ovf_at_done, 1);
    if (wd.size() == 1) chk("t7_wdata", wd[0], 32'h8000_0000);
    @(negedge clk_i);
    chk("t7_ovf_held", ovf_o, 1);
    mem[22] = 32'd2; mem[23] = 32'd3;
    launch(9'd22, 9'd23, 9'd81, 1'b0);
    chk("t7_ovf_cleared", ovf_o, 0);
    watch(20);
    show_run("ovf_clear");
    chk("t7b_ovf_at_done", ovf_at_done, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
